// File: rtl/channel_defs.sv
// Shared definitions for the channel sequencer: status bits,
// error flag positions, FSM encoding and bus helpers.
package channel_defs;

    localparam logic [7:0] ST_BUSY = 8'h08;
    localparam logic [7:0] ST_DE   = 8'h10;
    localparam logic [7:0] ST_CE   = 8'h20;
    localparam logic [7:0] ST_UC   = 8'h40;

    localparam int ERR_NODEV   = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_PARITY  = 2;
    localparam int ERR_ADDR    = 3;

    typedef enum logic [4:0] {
        S_IDLE,
        S_SEL_ADDR,
        S_SEL_HOLD,
        S_SEL_WAIT,
        S_ADDR_WAIT,
        S_CMD,
        S_CMD_DROP,
        S_ISTAT,
        S_ISTAT_END,
        S_DATA,
        S_WR_WAIT,
        S_WR_SETTLE,
        S_SVC_END,
        S_STOP_WAIT,
        S_ESTAT,
        S_ESTAT_END,
        S_RESET_IF
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic [15:0] sat_dec(input logic [15:0] n);
        return (n == 16'd0) ? 16'd0 : n - 16'd1;
    endfunction

endpackage

// File: rtl/channel_sequencer_timer.sv
// Per-state wait counter: gives both the bus settle delay and the
// tag-response timeout. Restarts whenever clear is high.
module tag_wait_timer
    import channel_defs::*;
#(
    parameter int W       = 11,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    output logic [W-1:0] elapsed,
    output logic         settled,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + W'(1);
        end
    end

    // elapsed reads 0 on the first cycle of every state
    assign elapsed = clear ? '0 : cnt;
    assign settled = elapsed >= W'(SETTLE - 1);
    assign expired = elapsed >= W'(TIMEOUT);

endmodule

// File: rtl/channel_sequencer.sv
// Channel-side sequencer: runs selection, command, initial status,
// byte-serial data, stop and ending status for one operation.
module channel_sequencer
    import channel_defs::*;
#(
    parameter int SETTLE       = 2,
    parameter int TIMEOUT      = 1024,
    parameter int RESET_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  start_address,
    input  logic [7:0]  start_command,
    input  logic [15:0] start_count,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  done_status,
    output logic [15:0] done_residual,
    output logic [3:0]  done_err,
    output logic [7:0]  bus_out,
    output logic        bus_out_parity,
    output logic        operational_out,
    output logic        hold_out,
    output logic        select_out,
    output logic        address_out,
    output logic        command_out,
    output logic        service_out,
    output logic        suppress_out,
    input  logic [7:0]  bus_in,
    input  logic        bus_in_parity,
    input  logic        request_in,
    input  logic        select_in,
    input  logic        operational_in,
    input  logic        address_in,
    input  logic        status_in,
    input  logic        service_in
);

    localparam int TW = $clog2(TIMEOUT + RESET_CYCLES + SETTLE + 1);

    state_t        state;
    state_t        last_state;
    logic [7:0]    addr;
    logic [7:0]    cmd;
    logic [15:0]   count;
    logic [TW-1:0] elapsed;
    logic          settled;
    logic          expired;
    logic          tmr_clear;
    logic          waiting;
    logic          par_bad;
    logic          stop_status;
    logic          unused_in;

    assign suppress_out = 1'b0;
    assign unused_in    = request_in;
    assign tmr_clear    = (state != last_state);
    assign par_bad      = (bus_in_parity != odd_parity(bus_in));
    assign stop_status  = ((done_status & ST_BUSY) != 8'h00) ||
                          ((done_status & (ST_CE | ST_DE)) == (ST_CE | ST_DE));
    assign waiting = state inside {S_SEL_WAIT, S_ADDR_WAIT, S_CMD_DROP,
                                   S_ISTAT, S_ISTAT_END, S_DATA, S_WR_WAIT,
                                   S_SVC_END, S_STOP_WAIT, S_ESTAT,
                                   S_ESTAT_END};

    tag_wait_timer #(
        .W       (TW),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .elapsed (elapsed),
        .settled (settled),
        .expired (expired)
    );

    task finish_op;
        done          <= 1'b1;
        busy          <= 1'b0;
        done_residual <= count;
        hold_out      <= 1'b0;
        select_out    <= 1'b0;
        address_out   <= 1'b0;
        command_out   <= 1'b0;
        service_out   <= 1'b0;
        state         <= S_IDLE;
    endtask

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            last_state      <= S_IDLE;
            addr            <= '0;
            cmd             <= '0;
            count           <= '0;
            wr_ready        <= 1'b0;
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            done_status     <= '0;
            done_residual   <= '0;
            done_err        <= '0;
            bus_out         <= '0;
            bus_out_parity  <= 1'b0;
            operational_out <= 1'b0;
            hold_out        <= 1'b0;
            select_out      <= 1'b0;
            address_out     <= 1'b0;
            command_out     <= 1'b0;
            service_out     <= 1'b0;
        end else begin
            last_state <= state;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            wr_ready   <= 1'b0;
            if (waiting && expired) begin
                // CU stopped answering: drop every tag and reset the interface
                done_err[ERR_TIMEOUT] <= 1'b1;
                operational_out <= 1'b0;
                hold_out        <= 1'b0;
                select_out      <= 1'b0;
                address_out     <= 1'b0;
                command_out     <= 1'b0;
                service_out     <= 1'b0;
                bus_out         <= '0;
                bus_out_parity  <= odd_parity(8'h00);
                state           <= S_RESET_IF;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        operational_out <= 1'b1;
                        if (start) begin
                            addr           <= start_address;
                            cmd            <= start_command;
                            count          <= start_count;
                            busy           <= 1'b1;
                            done_err       <= '0;
                            bus_out        <= start_address;
                            bus_out_parity <= odd_parity(start_address);
                            state          <= S_SEL_ADDR;
                        end
                    end
                    S_SEL_ADDR: begin
                        if (settled) begin
                            address_out <= 1'b1;
                            state       <= S_SEL_HOLD;
                        end
                    end
                    S_SEL_HOLD: begin
                        hold_out   <= 1'b1;
                        select_out <= 1'b1;
                        state      <= S_SEL_WAIT;
                    end
                    S_SEL_WAIT: begin
                        if (operational_in) begin
                            address_out <= 1'b0;
                            state       <= S_ADDR_WAIT;
                        end else if (select_in) begin
                            done_err[ERR_NODEV] <= 1'b1;
                            finish_op();
                        end
                    end
                    S_ADDR_WAIT: begin
                        if (address_in) begin
                            if (par_bad) done_err[ERR_PARITY] <= 1'b1;
                            if (bus_in != addr) done_err[ERR_ADDR] <= 1'b1;
                            select_out     <= 1'b0;
                            hold_out       <= 1'b0;
                            bus_out        <= cmd;
                            bus_out_parity <= odd_parity(cmd);
                            state          <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (settled) begin
                            command_out <= 1'b1;
                            state       <= S_CMD_DROP;
                        end
                    end
                    S_CMD_DROP: begin
                        if (!address_in) begin
                            command_out <= 1'b0;
                            state       <= S_ISTAT;
                        end
                    end
                    S_ISTAT, S_ESTAT: begin
                        if (status_in) begin
                            if (par_bad) done_err[ERR_PARITY] <= 1'b1;
                            done_status <= bus_in;
                            service_out <= 1'b1;
                            state <= (state == S_ISTAT) ? S_ISTAT_END
                                                        : S_ESTAT_END;
                        end
                    end
                    S_ISTAT_END: begin
                        if (!status_in) begin
                            service_out <= 1'b0;
                            if (stop_status) finish_op();
                            else state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (status_in) begin
                            if (par_bad) done_err[ERR_PARITY] <= 1'b1;
                            done_status <= bus_in;
                            service_out <= 1'b1;
                            state       <= S_ESTAT_END;
                        end else if (service_in) begin
                            if (count == 16'd0) begin
                                command_out <= 1'b1;
                                state       <= S_STOP_WAIT;
                            end else if (cmd[0]) begin
                                state <= S_WR_WAIT;
                            end else begin
                                if (par_bad) done_err[ERR_PARITY] <= 1'b1;
                                rd_data     <= bus_in;
                                rd_valid    <= 1'b1;
                                service_out <= 1'b1;
                                count       <= sat_dec(count);
                                state       <= S_SVC_END;
                            end
                        end
                    end
                    S_WR_WAIT: begin
                        // byte is taken here; wr_ready confirms it a cycle later
                        if (wr_valid) begin
                            bus_out        <= wr_data;
                            bus_out_parity <= odd_parity(wr_data);
                            wr_ready       <= 1'b1;
                            count          <= sat_dec(count);
                            state          <= S_WR_SETTLE;
                        end
                    end
                    S_WR_SETTLE: begin
                        if (settled) begin
                            service_out <= 1'b1;
                            state       <= S_SVC_END;
                        end
                    end
                    S_SVC_END: begin
                        if (!service_in) begin
                            service_out <= 1'b0;
                            state       <= S_DATA;
                        end
                    end
                    S_STOP_WAIT: begin
                        if (!service_in) begin
                            command_out <= 1'b0;
                            state       <= S_ESTAT;
                        end
                    end
                    S_ESTAT_END: begin
                        if (!status_in) finish_op();
                    end
                    S_RESET_IF: begin
                        if (elapsed == TW'(RESET_CYCLES - 1)) begin
                            operational_out <= 1'b1;
                            done            <= 1'b1;
                            busy            <= 1'b0;
                            done_residual   <= count;
                            state           <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed bench for channel_sequencer with a behavioural control unit
// answering on the tag lines.
module tb_channel_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_address = '0;
    logic [7:0]  start_command = '0;
    logic [15:0] start_count = '0;
    logic [7:0]  wr_data = 8'hA0;
    logic        wr_valid = 1'b1;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [7:0]  done_status;
    logic [15:0] done_residual;
    logic [3:0]  done_err;
    logic [7:0]  bus_out;
    logic        bus_out_parity;
    logic        operational_out, hold_out, select_out;
    logic        address_out, command_out, service_out, suppress_out;
    logic [7:0]  bus_in = '0;
    logic        bus_in_parity = 1'b1;
    logic        request_in = 1'b0;
    logic        select_in = 1'b0;
    logic        operational_in = 1'b0;
    logic        address_in = 1'b0;
    logic        status_in = 1'b0;
    logic        service_in = 1'b0;

    channel_sequencer #(
        .SETTLE       (2),
        .TIMEOUT      (32),
        .RESET_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_address   (start_address),
        .start_command   (start_command),
        .start_count     (start_count),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .busy            (busy),
        .done            (done),
        .done_status     (done_status),
        .done_residual   (done_residual),
        .done_err        (done_err),
        .bus_out         (bus_out),
        .bus_out_parity  (bus_out_parity),
        .operational_out (operational_out),
        .hold_out        (hold_out),
        .select_out      (select_out),
        .address_out     (address_out),
        .command_out     (command_out),
        .service_out     (service_out),
        .suppress_out    (suppress_out),
        .bus_in          (bus_in),
        .bus_in_parity   (bus_in_parity),
        .request_in      (request_in),
        .select_in       (select_in),
        .operational_in  (operational_in),
        .address_in      (address_in),
        .status_in       (status_in),
        .service_in      (service_in)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    // ---------------- behavioural control unit ----------------
    logic [7:0] cu_addr = 8'hFF;
    bit         cu_busy = 0, cu_noaddr = 0, cu_badpar = 0, cu_kill = 0;
    bit         cu_stop = 0, ab = 0;
    int         cu_limit = 0, cu_svc = 0, cu_nw = 0;
    logic [7:0] cu_wbuf [16];

    function automatic logic tag_of(input int idx);
        case (idx)
            0: return select_out;
            1: return address_out;
            2: return command_out;
            3: return service_out;
            4: return service_out | command_out;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wt(input int idx, input logic lvl);
        int n = 0;
        while (!ab && tag_of(idx) !== lvl) begin
            @(posedge clk); #1;
            n++;
            if (!operational_out || cu_kill || n > 300) ab = 1;
        end
    endtask

    task automatic drive_bus(input logic [7:0] v);
        bus_in = v;
        bus_in_parity = (~^v) ^ cu_badpar;
        cu_badpar = 0;
    endtask

    task automatic present_status(input logic [7:0] st);
        drive_bus(st);
        status_in = 1'b1;
        wt(3, 1'b1);
        if (ab) return;
        status_in = 1'b0;
        wt(3, 1'b0);
    endtask

    task automatic cu_once();
        logic [7:0] c;
        logic [7:0] st;
        int k;
        ab = 0;
        wt(0, 1'b1); if (ab) return;
        if (bus_out != cu_addr) begin
            select_in = 1'b1;
            wt(0, 1'b0);
            select_in = 1'b0;
            return;
        end
        operational_in = 1'b1;
        wt(1, 1'b0); if (ab) return;
        if (cu_noaddr) begin
            wt(2, 1'b1);
            return;
        end
        drive_bus(cu_addr);
        address_in = 1'b1;
        wt(2, 1'b1); if (ab) return;
        c = bus_out;
        address_in = 1'b0;
        wt(2, 1'b0); if (ab) return;
        if (cu_busy) st = 8'h08;
        else if (c == 8'h03) st = 8'h30;
        else st = 8'h00;
        present_status(st); if (ab) return;
        if (st != 8'h00) return;
        k = 0;
        while (k < cu_limit) begin
            drive_bus(8'h01 + k[7:0]);
            service_in = 1'b1;
            cu_svc++;
            wt(4, 1'b1); if (ab) return;
            if (command_out) begin
                service_in = 1'b0;
                cu_stop = 1;
                wt(2, 1'b0); if (ab) return;
                break;
            end
            if (c[0] && cu_nw < 16) begin
                cu_wbuf[cu_nw] = bus_out;
                cu_nw++;
            end
            service_in = 1'b0;
            wt(3, 1'b0); if (ab) return;
            k++;
        end
        present_status(8'h30);
    endtask

    initial begin
        wait (reset == 1'b0);
        forever begin
            cu_once();
            {operational_in, address_in, status_in, service_in, select_in} = '0;
            while (ab && (!operational_out || cu_kill)) begin
                @(posedge clk); #1;
            end
        end
    end

    // ---------------- host side ----------------
    bit         got_done;
    int         lat, nrd, nwr, low_cnt;
    logic [7:0] rd_buf [16];

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] c,
                          input logic [15:0] n, input int max_cycles,
                          input int stray_at);
        cu_svc = 0; cu_nw = 0; cu_stop = 0;
        wr_data = 8'hA0;
        start_address = a; start_command = c; start_count = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_done = 0; lat = -1; nrd = 0; nwr = 0; low_cnt = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            if (address_out && lat < 0) lat = i;
            if (rd_valid && nrd < 16) begin rd_buf[nrd] = rd_data; nrd++; end
            if (wr_ready) begin nwr++; wr_data = 8'hA0 + 8'(nwr); end
            if (!operational_out) low_cnt++;
            if (done) begin got_done = 1; break; end
            if (i == stray_at) begin
                start_count = 16'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw;
        int dn;
        idle(3);
        check("reset_outs",
              {busy, done, wr_ready, rd_valid, operational_out, hold_out,
               select_out, address_out, command_out, service_out,
               suppress_out, bus_out, bus_out_parity, done_status,
               done_err}, 32'h0);
        check("reset_resid", done_residual, 32'h0);
        reset = 1'b0;
        idle(1);
        check("idle_op", {operational_out, busy}, 32'h2);
        idle(3);

        // NOP
        run_op(8'hFF, 8'h03, 16'd5, 200, 0);
        check("nop_done", got_done, 1);
        check("nop_lat", lat, 3);
        check("nop_status", done_status, 32'h30);
        check("nop_err", done_err, 32'h0);
        check("nop_resid", done_residual, 32'd5);
        check("nop_busy", busy, 0);
        idle(5);

        // Read to CU limit, with an ignored start mid-operation
        cu_limit = 4;
        run_op(8'hFF, 8'h02, 16'd16, 400, 20);
        check("rd_done", got_done, 1);
        check("rd_nbytes", nrd, 4);
        check("rd_bytes", {rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3]},
              32'h01020304);
        check("rd_status", done_status, 32'h30);
        check("rd_resid", done_residual, 32'd12);
        check("rd_err", done_err, 32'h0);
        idle(5);

        // Write with stop
        cu_limit = 10;
        run_op(8'hFF, 8'h01, 16'd3, 400, 0);
        check("wr_done", got_done, 1);
        check("wr_ready_n", nwr, 3);
        check("wr_cu_bytes", {8'h00, cu_wbuf[0], cu_wbuf[1], cu_wbuf[2]},
              32'h00A0A1A2);
        check("wr_stop", cu_stop, 1);
        check("wr_svc_n", cu_svc, 4);
        check("wr_status", done_status, 32'h30);
        check("wr_resid", done_residual, 32'd0);
        check("wr_err", done_err, 32'h0);
        idle(5);

        // Busy CU
        cu_busy = 1;
        run_op(8'hFF, 8'h02, 16'd8, 200, 0);
        cu_busy = 0;
        check("busy_done", got_done, 1);
        check("busy_status", done_status, 32'h08);
        check("busy_xfers", nrd + nwr + cu_svc, 0);
        check("busy_resid", done_residual, 32'd8);
        idle(5);

        // No device
        run_op(8'h42, 8'h02, 16'd1, 200, 0);
        check("nodev_done", got_done, 1);
        check("nodev_err", done_err, 32'h1);
        check("nodev_tags",
              {busy, hold_out, select_out, address_out, command_out,
               service_out}, 32'h0);
        idle(2);
        check("nodev_op", operational_out, 1);
        idle(5);

        // Timeout: CU never raises address_in
        cu_noaddr = 1;
        run_op(8'hFF, 8'h02, 16'd4, 200, 0);
        cu_noaddr = 0;
        check("to_done", got_done, 1);
        check("to_err", done_err, 32'h2);
        check("to_op_low", low_cnt, 4);
        check("to_resid", done_residual, 32'd4);
        idle(8);

        // Bad parity on the returned address byte
        cu_badpar = 1;
        run_op(8'hFF, 8'h03, 16'd2, 200, 0);
        check("par_done", got_done, 1);
        check("par_err", done_err, 32'h4);
        check("par_status", done_status, 32'h30);
        idle(5);

        // Reset during data transfer
        cu_limit = 10;
        start_address = 8'hFF; start_command = 8'h02; start_count = 16'd16;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        saw = 0;
        for (int i = 0; i < 200 && !saw; i++) begin
            if (rd_valid) saw = 1;
            else idle(1);
        end
        check("rst_rd_seen", saw, 1);
        reset = 1'b1;
        cu_kill = 1;
        idle(1);
        reset = 1'b0;
        check("rst_outs",
              {busy, done, operational_out, hold_out, select_out,
               address_out, command_out, service_out}, 32'h0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (done) dn++;
        end
        check("rst_no_done", dn, 0);
        check("rst_idle", {operational_out, busy}, 32'h2);
        cu_kill = 0;
        idle(5);

        // Recovery after reset
        run_op(8'hFF, 8'h03, 16'd9, 200, 0);
        check("rec_done", got_done, 1);
        check("rec_status", done_status, 32'h30);
        check("rec_err", done_err, 32'h0);
        check("rec_resid", done_residual, 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/channel_sequencer.md
# channel_sequencer

Channel-side controller that runs one complete I/O operation on the parallel bus-and-tag interface: initial selection, command transfer, initial status, byte-serial data transfer, stop, and ending status. It sits between a host command/data port and the channel "A" side of the tee, and is the block that drives control units such as the mock CU. One operation is in flight at a time. Every outcome is reported as a final status byte, a residual count and error flags.

## Interface
- `SETTLE`, 2: cycles `bus_out` is held stable before raising `address_out`, `command_out` or `service_out`.
- `TIMEOUT`, 1024: maximum cycles spent waiting on any single CU tag transition.
- `RESET_CYCLES`, 4: cycles `operational_out` is held low after a timeout.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request, accepted only while `busy`=0.
- `start_address` in 8: device address.
- `start_command` in 8: command byte. Bit 0 = 1 is write (channel to CU); bit 0 = 0 is read.
- `start_count` in 16: number of bytes to transfer.
- `wr_data` / `wr_valid` in 8/1, `wr_ready` out 1: write byte stream.
- `rd_data` out 8, `rd_valid` out 1: read byte stream. `rd_valid` is a one-cycle pulse with no backpressure.
- `busy` out 1: an operation is in progress.
- `done` out 1: one-cycle pulse when an operation finishes.
- `done_status` out 8: last status byte received.
- `done_residual` out 16: bytes remaining.
- `done_err` out 4: error flags.
- `bus_out`, `bus_out_parity` out 8/1: odd parity.
- `operational_out`, `hold_out`, `select_out`, `address_out`, `command_out`, `service_out`, `suppress_out` out 1 each.
- `bus_in`, `bus_in_parity` in 8/1.
- `request_in`, `select_in`, `operational_in`, `address_in`, `status_in`, `service_in` in 1 each.

## Operation
- **Reset:** every output is 0 and the block enters `IDLE`. `operational_out` is set to 1 on the first `IDLE` cycle. `suppress_out` is always 0. `request_in` is ignored in this revision.
- **`IDLE`:** on `start`, latch address, command and count, set `busy`, place the address on `bus_out` and go to `SEL_ADDR`.
- **`SEL_ADDR`:** after `SETTLE` cycles, raise `address_out`, then raise `hold_out` and `select_out` on the next cycle. Go to `SEL_WAIT`.
- **`SEL_WAIT`:**
  - `operational_in`: drop `address_out` and go to `ADDR_WAIT`.
  - `select_in` returned: no device. Set `err[0]`, drop all tags and finish.
- **`ADDR_WAIT`:** on `address_in`:
  - Compare `bus_in` with the latched address; a mismatch sets `err[3]`.
  - Drop `select_out` and `hold_out`.
  - Drive the command byte and go to `CMD`.
- **`CMD`:** after `SETTLE` cycles, raise `command_out` and wait for `address_in`=0.
- **`CMD_DROP`:** drop `command_out` and wait for `status_in`.
- **`ISTAT`:** on `status_in`:
  - Capture `bus_in` into `done_status` and raise `service_out`.
  - Wait for `status_in`=0, then drop `service_out`.
  - If the status has BUSY set, or has both CE and DE set, finish. Otherwise go to `DATA`.
- **`DATA`, on `service_in`:**
  - **Count 0:** raise `command_out` (stop), wait for `service_in`=0, drop `command_out`, go to `ESTAT`.
  - **Write:** wait for `wr_valid`. Drive `wr_data`, pulse `wr_ready`, raise `service_out` after `SETTLE` cycles. Decrement the count.
  - **Read:** capture `bus_in` into `rd_data`, pulse `rd_valid`, raise `service_out`. Decrement the count.
  - After a transfer, wait for `service_in`=0, drop `service_out` and stay in `DATA`.
- **`DATA`, on `status_in`:** the CU ended early; go directly to `ESTAT` handling.
- **`ESTAT`:** on `status_in`:
  - Capture `done_status`, raise `service_out`, wait for `status_in`=0, drop `service_out`.
  - Pulse `done` and clear `busy`. `done_residual` = remaining count.
- **Timeout:** any wait exceeding `TIMEOUT` sets `err[1]` and enters `RESET_IF`. In `RESET_IF` all tags are low, including `operational_out`, for `RESET_CYCLES`; then `done` pulses.
- **Parity:** any `bus_in` sample with bad odd parity sets `err[2]` and the operation continues.
- **`done_err`:** cleared on `start`.
- **Completion of `operational_in`:** not waited for at completion; the CU may leave it asserted.

## Timing
- Inputs are synchronous to `clk`, as delivered by the tee.
- Each tag response registers one cycle after the triggering input level is sampled.
- `start` to `address_out`: `SETTLE`+1 cycles.
- `start` asserted while `busy`=1 is ignored.
- `done` and the final values of `done_status`, `done_residual` and `done_err` appear in the same cycle and hold until the next `start`.
- `busy` falls in the same cycle that `done` pulses.
- `start_count`=0 with a data command: the first `service_in` is answered with stop; no bytes move.
- The count decrements saturate at 0, and the residual never wraps.
- `reset` mid-operation: returns to `IDLE` in one cycle with all tags low. `done` is not pulsed.
- The timeout counter restarts on every state change.

## Structure
- Shared package `channel_defs`:
  - Status bit constants: BUSY=0x08, DE=0x10, CE=0x20, UC=0x40.
  - `done_err` bit indices.
  - State encoding.
  - Odd-parity function.
- One sub-module, `tag_wait_timer`: a load/clear wait counter that provides both the `SETTLE` delay and the `TIMEOUT` detection.

## Test plan
- **NOP:** mock CU at 0xFF with command 0x03. Required: `done` with `done_status`=0x30, `err`=0, residual = `start_count`.
- **Read to limit:** read 0x02 with count 16 and `mock_limit`=4. Required: `rd_data` 01..04, `done_status`=0x30, `done_residual`=12.
- **Write with stop:** write 0x01 with count 3 and `mock_limit`=10. Required: 3 `wr_ready` pulses, stop on the 4th `service_in`, `done_status`=0x30, residual 0.
- **Busy CU:** `mock_busy`=1. Required: `done_status`=0x08 after the initial status, and no `service_in` handled.
- **No device:** address 0x42 with no CU present. Required: `select_in` returns, `err[0]`=1, all tags low within 2 cycles.
- **Timeout, parity and reset:** a CU that never raises `address_in`, with `TIMEOUT`=32. Required: `err[1]`, `operational_out` low for 4 cycles. Separately, injecting a bad `bus_in_parity` byte sets `err[2]`, and `reset` asserted during `DATA` returns the block to `IDLE` with no `done`.
